// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding controller
// Tag indices are held at TAG_AW bits; narrower register indices are zero-extended.
package hazard_pkg;

   localparam int TAG_AW = 8;

   typedef logic [TAG_AW-1:0] tag_rd_t;

   localparam tag_rd_t REG_ZERO = '0;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_ME  = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic    valid;
      tag_rd_t rd;
      logic    ru_write;
      logic    is_load;
   } stage_tag_t;

   function automatic logic tag_live(input logic valid, input logic ru_write, input tag_rd_t rd);
      return valid & ru_write & (rd != REG_ZERO);
   endfunction

endpackage

// File: rtl/fwd_compare.sv
// rtl/fwd_compare.sv - forwarding source select for one EX operand
// ME wins over WB when both hold the same live destination.
module fwd_compare
   import hazard_pkg::*;
(
   input  logic     uses,
   input  tag_rd_t  src,
   input  logic     me_live,
   input  tag_rd_t  me_rd,
   input  logic     wb_live,
   input  tag_rd_t  wb_rd,
   output fwd_sel_e sel
);

   always_comb begin
      sel = FWD_REG;
      if (uses && me_live && (me_rd == src)) begin
         sel = FWD_ME;
      end else if (uses && wb_live && (wb_rd == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - EX/ME/WB tag shadow, forwarding, load-use stall and jump flush
// Define HAZARD_PERF_CNT_EN to add saturating stall_count/flush_count outputs.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW           = 5,
   parameter bit RF_WRITE_THROUGH = 1'b1
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W            = 32
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              de_valid,
   input  logic [REG_AW-1:0] de_rs1,
   input  logic [REG_AW-1:0] de_rs2,
   input  logic              de_uses_rs1,
   input  logic              de_uses_rs2,
   input  logic [REG_AW-1:0] de_rd,
   input  logic              de_ru_write,
   input  logic              de_is_load,
   input  logic              ex_jump,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count,
`endif
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall_if,
   output logic              stall_de,
   output logic              flush_de,
   output logic              flush_ex
);

   stage_tag_t ex_tag, me_tag, wb_tag;
   tag_rd_t    ex_rs1, ex_rs2;
   logic       ex_uses_rs1, ex_uses_rs2;

   tag_rd_t d_rs1, d_rs2, d_rd;
   logic    ex_live, me_live, wb_live;
   logic    load_use, wb_rd_hazard, stall, flush_ex_int;
   fwd_sel_e sel_a, sel_b;

   // WB is_load is carried so every stage has the same tag layout.
   logic tag_unused;
   assign tag_unused = wb_tag.is_load;

   assign d_rs1 = tag_rd_t'(de_rs1);
   assign d_rs2 = tag_rd_t'(de_rs2);
   assign d_rd  = tag_rd_t'(de_rd);

   assign ex_live = tag_live(ex_tag.valid, ex_tag.ru_write, ex_tag.rd);
   assign me_live = tag_live(me_tag.valid, me_tag.ru_write, me_tag.rd);
   assign wb_live = tag_live(wb_tag.valid, wb_tag.ru_write, wb_tag.rd);

   assign load_use = de_valid & ex_live & ex_tag.is_load &
                     ((de_uses_rs1 & (d_rs1 == ex_tag.rd)) |
                      (de_uses_rs2 & (d_rs2 == ex_tag.rd)));

   assign wb_rd_hazard = !RF_WRITE_THROUGH & de_valid & wb_live &
                         ((de_uses_rs1 & (d_rs1 == wb_tag.rd)) |
                          (de_uses_rs2 & (d_rs2 == wb_tag.rd)));

   assign stall        = (load_use | wb_rd_hazard) & ~ex_jump;
   assign flush_ex_int = stall | ex_jump;

   fwd_compare u_fwd_a (
      .uses    (ex_uses_rs1 & ex_tag.valid),
      .src     (ex_rs1),
      .me_live (me_live),
      .me_rd   (me_tag.rd),
      .wb_live (wb_live),
      .wb_rd   (wb_tag.rd),
      .sel     (sel_a)
   );

   fwd_compare u_fwd_b (
      .uses    (ex_uses_rs2 & ex_tag.valid),
      .src     (ex_rs2),
      .me_live (me_live),
      .me_rd   (me_tag.rd),
      .wb_live (wb_live),
      .wb_rd   (wb_tag.rd),
      .sel     (sel_b)
   );

   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      stall_if  = 1'b0;
      stall_de  = 1'b0;
      flush_de  = 1'b0;
      flush_ex  = 1'b0;
      if (!reset) begin
         fwd_a_sel = sel_a;
         fwd_b_sel = sel_b;
         stall_if  = stall;
         stall_de  = stall;
         flush_de  = ex_jump;
         flush_ex  = flush_ex_int;
      end
   end

   // A stalled DE re-presents its fields next cycle, so EX only takes a bubble here.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_tag      <= '0;
         me_tag      <= '0;
         wb_tag      <= '0;
         ex_rs1      <= REG_ZERO;
         ex_rs2      <= REG_ZERO;
         ex_uses_rs1 <= 1'b0;
         ex_uses_rs2 <= 1'b0;
      end else begin
         wb_tag <= me_tag;
         me_tag <= ex_tag;
         if (flush_ex_int) begin
            ex_tag      <= '0;
            ex_rs1      <= REG_ZERO;
            ex_rs2      <= REG_ZERO;
            ex_uses_rs1 <= 1'b0;
            ex_uses_rs2 <= 1'b0;
         end else begin
            ex_tag      <= '{valid: de_valid, rd: d_rd, ru_write: de_ru_write, is_load: de_is_load};
            ex_rs1      <= d_rs1;
            ex_rs2      <= d_rs2;
            ex_uses_rs1 <= de_uses_rs1;
            ex_uses_rs2 <= de_uses_rs2;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (ex_jump && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
// dut0 uses the write-through register file, dut1 does not.
module tb_hazard_ctrl_unit;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       jmp;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       de_valid, de_uses_rs1, de_uses_rs2, de_ru_write, de_is_load, ex_jump;
   logic [4:0] de_rs1, de_rs2, de_rd;
   logic [1:0] fa0, fb0, fa1, fb1;
   logic       sif0, sde0, fde0, fex0, sif1, sde1, fde1, fex1;
   logic [7:0] obs0, obs1;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] sb[$];
   logic [7:0] sb1[$];
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] sc0, fc0, sc1, fc1;
`endif

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_AW(5), .RF_WRITE_THROUGH(1'b1)) dut0 (
      .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
      .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2), .de_rd(de_rd),
      .de_ru_write(de_ru_write), .de_is_load(de_is_load), .ex_jump(ex_jump),
`ifdef HAZARD_PERF_CNT_EN
      .stall_count(sc0), .flush_count(fc0),
`endif
      .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_if(sif0), .stall_de(sde0),
      .flush_de(fde0), .flush_ex(fex0)
   );

   hazard_ctrl_unit #(.REG_AW(5), .RF_WRITE_THROUGH(1'b0)) dut1 (
      .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
      .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2), .de_rd(de_rd),
      .de_ru_write(de_ru_write), .de_is_load(de_is_load), .ex_jump(ex_jump),
`ifdef HAZARD_PERF_CNT_EN
      .stall_count(sc1), .flush_count(fc1),
`endif
      .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_if(sif1), .stall_de(sde1),
      .flush_de(fde1), .flush_ex(fex1)
   );

   assign obs0 = {fa0, fb0, sif0, sde0, fde0, fex0};
   assign obs1 = {fa1, fb1, sif1, sde1, fde1, fex1};

   function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld);
      stim_t st;
      st = '{rst: 1'b0, v: v, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, wr: wr, ld: ld, jmp: 1'b0};
      return st;
   endfunction

   function automatic logic [7:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic st, input logic fde, input logic fex);
      return {fa, fb, st, st, fde, fex};
   endfunction

   task automatic drive(input stim_t st);
      reset       = st.rst;
      de_valid    = st.v;
      de_rs1      = st.rs1;
      de_rs2      = st.rs2;
      de_uses_rs1 = st.u1;
      de_uses_rs2 = st.u2;
      de_rd       = st.rd;
      de_ru_write = st.wr;
      de_is_load  = st.ld;
      ex_jump     = st.jmp;
   endtask

   task automatic test_reset();
      stim_t st;
      logic [7:0] exp;
      for (int i = 0; i < 3; i++) begin
         st = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         st.jmp = 1'($urandom_range(0, 1));
         st.rst = (i < 2);
         if (i == 2) st = mk(0, 0, 0, 0, 0, 0, 0, 0);
         drive(st);
         sb.push_back(8'h00);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if ({obs0, obs1} !== {exp, exp}) begin
            $display("FAIL reset[%0d] got dut0=%b dut1=%b want %b", i, obs0, obs1, exp);
            miscompares++;
         end
`ifdef HAZARD_PERF_CNT_EN
         if (i == 2) begin
            vectors++;
            if ({sc0, fc0} !== 64'd0) begin
               $display("FAIL reset_counters got stall=%0d flush=%0d want 0 0", sc0, fc0);
               miscompares++;
            end
         end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_back_to_back();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0));  e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0));  e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 2, 5, 1, 1, 11, 1, 0)); e.push_back(ev(2'b01, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  e.push_back(ev(2'b00, 2'b10, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if (obs0 !== exp) begin
            $display("FAIL alu_b2b[%0d] got %b want %b", i, obs0, exp);
            miscompares++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_double_hit();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 1, 0, 1, 0, 3, 1, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b01, 2'b01, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if (obs0 !== exp) begin
            $display("FAIL double_hit[%0d] got %b want %b", i, obs0, exp);
            miscompares++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1));   e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0));   e.push_back(ev(2'b00, 2'b00, 1, 0, 1));
      s.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0));   e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 3, 0, 1, 0, 12, 1, 1));  e.push_back(ev(2'b10, 2'b00, 0, 0, 0));
      s.push_back(mk(1, 1, 12, 0, 1, 13, 1, 0)); e.push_back(ev(2'b00, 2'b00, 1, 0, 1));
      s.push_back(mk(1, 1, 12, 0, 1, 13, 1, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   e.push_back(ev(2'b00, 2'b10, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if (obs0 !== exp) begin
            $display("FAIL load_use[%0d] got %b want %b", i, obs0, exp);
            miscompares++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump_collision();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      stim_t st;
`ifdef HAZARD_PERF_CNT_EN
      logic [31:0] sc_before, fc_before;
      sc_before = '0;
      fc_before = '0;
`endif
      s.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      st = mk(1, 8, 1, 1, 1, 9, 1, 0);
      st.jmp = 1'b1;
      s.push_back(st);                         e.push_back(ev(2'b00, 2'b00, 0, 1, 1));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(2'b00, 2'b00, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if (obs0 !== exp) begin
            $display("FAIL jump_collision[%0d] got %b want %b", i, obs0, exp);
            miscompares++;
         end
`ifdef HAZARD_PERF_CNT_EN
         if (i == 1) begin
            sc_before = sc0;
            fc_before = fc0;
         end
         if (i == 2) begin
            vectors++;
            if ({sc0, fc0} !== {sc_before, fc_before + 32'd1}) begin
               $display("FAIL jump_counters got stall=%0d flush=%0d want %0d %0d",
                        sc0, fc0, sc_before, fc_before + 32'd1);
               miscompares++;
            end
         end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_x0_and_write_through();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] e1[$];
      logic [7:0] exp, exp1;
      s.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(1, 1, 2, 1, 1, 4, 1, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(1, 4, 0, 1, 0, 9, 1, 0)); e.push_back(8'h00);                    e1.push_back(ev(2'b00, 2'b00, 1, 0, 1));
      s.push_back(mk(1, 4, 0, 1, 0, 9, 1, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);                    e1.push_back(8'h00);
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         sb1.push_back(e1[i]);
         @(negedge clk);
         exp  = sb.pop_front();
         exp1 = sb1.pop_front();
         vectors++;
         if (obs0 !== exp) begin
            $display("FAIL x0_wt1[%0d] got %b want %b", i, obs0, exp);
            miscompares++;
         end
         vectors++;
         if (obs1 !== exp1) begin
            $display("FAIL x0_wt0[%0d] got %b want %b", i, obs1, exp1);
            miscompares++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      stim_t st;
      s.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1)); e.push_back(8'h00);
      st = mk(1, 8, 0, 1, 0, 9, 1, 0);
      st.rst = 1'b1;
      s.push_back(st);                         e.push_back(8'h00);
      s.push_back(mk(1, 8, 0, 1, 0, 9, 1, 0)); e.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(8'h00);
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(negedge clk);
         exp = sb.pop_front();
         vectors++;
         if ({obs0, obs1} !== {exp, exp}) begin
            $display("FAIL reset_mid_stall[%0d] got dut0=%b dut1=%b want %b", i, obs0, obs1, exp);
            miscompares++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      drive('{rst: 1'b1, default: '0});
      test_reset();
      test_alu_back_to_back();
      test_double_hit();
      test_load_use();
      test_jump_collision();
      test_x0_and_write_through();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
